// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive frame controller
// and the byte-wide CRC-32 helper.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_PAY,
    ST_DROP
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  localparam int HDR_LEN = 14;
  localparam int FCS_LEN = 4;
  localparam logic [2:0] PRE_MAX = 3'd7;

  localparam int ERR_CRC   = 0;
  localparam int ERR_LEN   = 1;
  localparam int ERR_TRUNC = 2;

  // Byte idx of a MAC address in wire order (idx 0 = most significant byte).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] sh;
    sh = mac << (8 * idx);
    return sh[47:40];
  endfunction

endpackage

// File: rtl/eth_rx_frame_ctrl_crc32_d8.sv
// Combinational reflected CRC-32 update for one byte, LSB first.
// Shared between the receive controller and the transmit framer.
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) crc_out = (crc_out >> 1) ^ CRC_POLY;
      else                      crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Receive frame controller: strips preamble/SFD, filters on destination MAC,
// forwards payload without FCS and reports CRC/length status at end of frame.
module eth_rx_frame_ctrl
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h000A_3501_FEC0,
  parameter int          MIN_LEN   = 64,
  parameter int          MAX_LEN   = 1518
) (
  input  logic        eth_rxc,
  input  logic        rst_n,
  input  logic [7:0]  rx_databyte,
  input  logic        rx_databyte_en,
  output logic [7:0]  pld_data,
  output logic        pld_valid,
  output logic        pld_sof,
  output logic [15:0] eth_type,
  output logic [47:0] src_mac,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [2:0]  frame_err,
  output logic [15:0] pld_len
);

  localparam logic [15:0] MIN_L    = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L    = 16'(MAX_LEN);
  localparam logic [3:0]  DA_LAST  = 4'd5;
  localparam logic [3:0]  HDR_LAST = 4'(HDR_LEN - 1);
  localparam logic [15:0] EMIT_AT  = 16'(HDR_LEN + FCS_LEN);

  rx_state_e   state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  hdr_cnt_q, hdr_cnt_d;
  logic [31:0] crc_q, crc_d, crc_next;
  logic [15:0] len_q, len_d, len_inc;
  logic        ucast_q, ucast_d, bcast_q, bcast_d;
  logic [55:0] hdr_sh_q, hdr_sh_d;
  logic [31:0] dly_q, dly_d;
  logic [7:0]  pld_data_q, pld_data_d;
  logic        pld_valid_q, pld_valid_d;
  logic        pld_sof_q, pld_sof_d;
  logic [15:0] eth_type_q, eth_type_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic [2:0]  frame_err_q, frame_err_d;
  logic [15:0] pld_len_q, pld_len_d;
  logic [2:0]  err_v;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (rx_databyte),
    .crc_out (crc_next)
  );

  assign len_inc = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    hdr_cnt_d    = hdr_cnt_q;
    crc_d        = crc_q;
    len_d        = len_q;
    ucast_d      = ucast_q;
    bcast_d      = bcast_q;
    hdr_sh_d     = hdr_sh_q;
    dly_d        = dly_q;
    pld_data_d   = 8'd0;
    pld_valid_d  = 1'b0;
    pld_sof_d    = 1'b0;
    eth_type_d   = eth_type_q;
    src_mac_d    = src_mac_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    frame_err_d  = frame_err_q;
    pld_len_d    = pld_len_q;
    err_v        = 3'd0;

    case (state_q)
      ST_IDLE: begin
        if (rx_databyte_en) begin
          if (rx_databyte == PREAMBLE_BYTE) begin
            state_d   = ST_PRE;
            pre_cnt_d = 3'd1;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_PRE: begin
        if (!rx_databyte_en) begin
          state_d = ST_IDLE;
        end else if (rx_databyte == PREAMBLE_BYTE) begin
          if (pre_cnt_q == PRE_MAX) state_d = ST_DROP;
          else                      pre_cnt_d = pre_cnt_q + 3'd1;
        end else if (rx_databyte == SFD_BYTE) begin
          state_d   = ST_HDR;
          hdr_cnt_d = 4'd0;
          crc_d     = CRC_INIT;
          len_d     = 16'd0;
          ucast_d   = 1'b1;
          bcast_d   = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end

      ST_HDR: begin
        if (!rx_databyte_en) begin
          // Once the DA has matched, an early end is reported as truncated.
          if (hdr_cnt_q > DA_LAST) begin
            frame_done_d = 1'b1;
            frame_ok_d   = 1'b0;
            frame_err_d  = 3'b100;
            pld_len_d    = 16'd0;
          end
          state_d = ST_IDLE;
        end else begin
          crc_d     = crc_next;
          len_d     = len_inc;
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          if (hdr_cnt_q <= DA_LAST) begin
            ucast_d = ucast_q & (rx_databyte == mac_byte(LOCAL_MAC, hdr_cnt_q[2:0]));
            bcast_d = bcast_q & (rx_databyte == mac_byte(BCAST_MAC, hdr_cnt_q[2:0]));
            if (hdr_cnt_q == DA_LAST && !ucast_d && !bcast_d) state_d = ST_DROP;
          end else if (hdr_cnt_q < HDR_LAST) begin
            hdr_sh_d = {hdr_sh_q[47:0], rx_databyte};
          end else begin
            src_mac_d  = hdr_sh_q[55:8];
            eth_type_d = {hdr_sh_q[7:0], rx_databyte};
            state_d    = ST_PAY;
          end
        end
      end

      ST_PAY: begin
        if (!rx_databyte_en) begin
          // The four bytes still in the delay line are the FCS.
          err_v[ERR_CRC] = (crc_q != CRC_RESIDUE);
          err_v[ERR_LEN] = (len_q < MIN_L) || (len_q > MAX_L);
          frame_done_d   = 1'b1;
          frame_err_d    = err_v;
          frame_ok_d     = (err_v == 3'd0);
          pld_len_d      = (len_q >= EMIT_AT) ? len_q - EMIT_AT : 16'd0;
          state_d        = ST_IDLE;
        end else begin
          crc_d = crc_next;
          len_d = len_inc;
          dly_d = {dly_q[23:0], rx_databyte};
          if (len_q >= EMIT_AT) begin
            pld_valid_d = 1'b1;
            pld_data_d  = dly_q[31:24];
            pld_sof_d   = (len_q == EMIT_AT);
          end
        end
      end

      ST_DROP: begin
        if (!rx_databyte_en) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge eth_rxc or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pre_cnt_q    <= 3'd0;
      hdr_cnt_q    <= 4'd0;
      crc_q        <= 32'd0;
      len_q        <= 16'd0;
      ucast_q      <= 1'b0;
      bcast_q      <= 1'b0;
      hdr_sh_q     <= 56'd0;
      dly_q        <= 32'd0;
      pld_data_q   <= 8'd0;
      pld_valid_q  <= 1'b0;
      pld_sof_q    <= 1'b0;
      eth_type_q   <= 16'd0;
      src_mac_q    <= 48'd0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 3'd0;
      pld_len_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      hdr_cnt_q    <= hdr_cnt_d;
      crc_q        <= crc_d;
      len_q        <= len_d;
      ucast_q      <= ucast_d;
      bcast_q      <= bcast_d;
      hdr_sh_q     <= hdr_sh_d;
      dly_q        <= dly_d;
      pld_data_q   <= pld_data_d;
      pld_valid_q  <= pld_valid_d;
      pld_sof_q    <= pld_sof_d;
      eth_type_q   <= eth_type_d;
      src_mac_q    <= src_mac_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      pld_len_q    <= pld_len_d;
    end
  end

  assign pld_data   = pld_data_q;
  assign pld_valid  = pld_valid_q;
  assign pld_sof    = pld_sof_q;
  assign eth_type   = eth_type_q;
  assign src_mac    = src_mac_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign pld_len    = pld_len_q;

endmodule
